// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared state type, 7-segment table and BCD saturating add
package scoreboard_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, EVAL, NEXT, DONE} state_t;

  // Active-high gfedcba patterns for digits 9 (top) down to 0 (bottom)
  localparam logic [69:0] SEG_TABLE = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                       7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

  // Adds a single-digit value to a packed BCD number of 'digits' digits; clamps to all-9s
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a,
                                               input logic [3:0]  add,
                                               input int          digits);
    logic [15:0] sum;
    logic [4:0]  acc;
    logic [3:0]  inc;
    sum = a;
    inc = add;
    for (int i = 0; i < 4; i++) begin
      if (i < digits) begin
        acc = {1'b0, a[i*4 +: 4]} + {1'b0, inc};
        if (acc > 5'd9) begin
          sum[i*4 +: 4] = 4'(acc - 5'd10);
          inc = 4'd1;
        end else begin
          sum[i*4 +: 4] = acc[3:0];
          inc = 4'd0;
        end
      end
    end
    if (inc != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (i < digits) sum[i*4 +: 4] = 4'd9;
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - one BCD digit to active-high 7-segment pattern, blank above 9
module bcd_to_seg7
  import scoreboard_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = (i_bcd > 4'd9) ? 7'h00 : SEG_TABLE[7*i_bcd +: 7];

endmodule

// File: rtl/scoreboard_controller_gen.sv
// rtl/scoreboard_controller_gen.sv - multi-level timed round scoreboard with BCD score, timer and 7-segment drive
module scoreboard_controller_gen
  import scoreboard_pkg::*;
#(
  parameter int PTS_DIGITS = 3,
  parameter int TIME_SEC   = 60,
  parameter int BONUS_SEC  = 15,
  parameter int NUM_LEVELS = 2,
  parameter int PASS_STEP  = 20,
  parameter int PTS_NORMAL = 2,
  parameter int PTS_BONUS  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          st,
  input  logic                          pt,
  output logic                          done,
  output logic                          pass,
  output logic [3:0]                    level_bcd,
  output logic [7:0]                    timer_bcd,
  output logic [4*PTS_DIGITS-1:0]       points_bcd,
  output logic [7*(PTS_DIGITS+3)-1:0]   seg7
);

  localparam int PW        = 4 * PTS_DIGITS;
  localparam int NSEG      = PTS_DIGITS + 3;
  localparam int MAX_SCORE = 10 ** PTS_DIGITS - 1;
  localparam int SW        = $clog2(MAX_SCORE + 1);
  localparam logic [7:0] TIME_BCD = 8'(((TIME_SEC / 10) * 16) + (TIME_SEC % 10));

  state_t        r_state, w_next;
  logic          r_st_q, r_pt_q, r_done, r_pass;
  logic [3:0]    r_level;
  logic [7:0]    r_timer, w_timer_dec;
  logic [15:0]   r_points, w_points_sum;
  logic [SW-1:0] r_shadow, w_shadow_sum;
  logic [3:0]    w_add;
  logic          w_st_e, w_pt_e, w_bonus, w_lvl_ok, w_last_lvl;

  assign w_st_e     = st & ~r_st_q;
  assign w_pt_e     = pt & ~r_pt_q;
  assign w_bonus    = (int'(r_timer[7:4]) * 10 + int'(r_timer[3:0])) <= BONUS_SEC;
  assign w_add      = w_bonus ? 4'(PTS_BONUS) : 4'(PTS_NORMAL);
  assign w_lvl_ok   = int'(r_shadow) >= int'(r_level) * PASS_STEP;
  assign w_last_lvl = (r_level == 4'(NUM_LEVELS));
  assign w_timer_dec = (r_timer[3:0] == 4'd0) ? {r_timer[7:4] - 4'd1, 4'd9}
                                              : {r_timer[7:4], r_timer[3:0] - 4'd1};
  assign w_points_sum = bcd_add_sat(r_points, w_add, PTS_DIGITS);
  assign w_shadow_sum = (int'(r_shadow) + int'(w_add) > MAX_SCORE) ? SW'(MAX_SCORE)
                                                                   : r_shadow + SW'(w_add);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_st_e) w_next = LOAD;
      LOAD:    w_next = PLAY;
      PLAY:    if (r_timer == 8'h00) w_next = EVAL;
      EVAL:    w_next = (w_lvl_ok && !w_last_lvl) ? NEXT : DONE;
      NEXT:    w_next = PLAY;
      DONE:    if (w_st_e) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_q   <= 1'b0;
      r_pt_q   <= 1'b0;
      r_points <= '0;
      r_shadow <= '0;
      r_timer  <= TIME_BCD;
      r_level  <= 4'd1;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_st_q <= st;
      r_pt_q <= pt;
      case (r_state)
        LOAD: begin
          r_points <= '0;
          r_shadow <= '0;
          r_timer  <= TIME_BCD;
          r_level  <= 4'd1;
          r_done   <= 1'b0;
          r_pass   <= 1'b0;
        end
        PLAY: begin
          // Bonus decision above reads the pre-tick timer, so a coincident tick does not affect it
          if (tick && r_timer != 8'h00) r_timer <= w_timer_dec;
          if (w_pt_e) begin
            r_points <= w_points_sum;
            r_shadow <= w_shadow_sum;
          end
        end
        EVAL: begin
          if (!(w_lvl_ok && !w_last_lvl)) begin
            r_done <= 1'b1;
            r_pass <= w_lvl_ok;
          end
        end
        NEXT: begin
          r_level <= r_level + 4'd1;
          r_timer <= TIME_BCD;
        end
        default: ;
      endcase
    end
  end

  assign done       = r_done;
  assign pass       = r_pass;
  assign level_bcd  = r_level;
  assign timer_bcd  = r_timer;
  assign points_bcd = r_points[PW-1:0];

  logic [4*NSEG-1:0] w_codes;
  assign w_codes = {r_points[PW-1:0], r_timer, r_level};

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    bcd_to_seg7 u_seg (
      .i_bcd (w_codes[4*k +: 4]),
      .o_seg (seg7[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_scoreboard_controller_gen.sv
// tb/tb_scoreboard_controller_gen.sv - directed and random checks of two scoreboard widths against a reference model
module tb_scoreboard_controller_gen;

  localparam int TIME_SEC   = 60;
  localparam int BONUS_SEC  = 15;
  localparam int NUM_LEVELS = 2;
  localparam int PASS_STEP  = 20;
  localparam int PTS_NORMAL = 2;
  localparam int PTS_BONUS  = 3;

  localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_EVAL = 3, P_NEXT = 4, P_DONE = 5;

  logic clk = 1'b0;
  logic rst = 1'b1, tick = 1'b0, st = 1'b0, pt = 1'b0;

  logic        done, pass, done2, pass2;
  logic [3:0]  level_bcd, level2;
  logic [7:0]  timer_bcd, timer2;
  logic [11:0] points_bcd;
  logic [7:0]  points2;
  logic [41:0] seg7;
  logic [34:0] seg7_2;

  always #5 clk = ~clk;

  scoreboard_controller_gen #(
    .PTS_DIGITS(3), .TIME_SEC(TIME_SEC), .BONUS_SEC(BONUS_SEC), .NUM_LEVELS(NUM_LEVELS),
    .PASS_STEP(PASS_STEP), .PTS_NORMAL(PTS_NORMAL), .PTS_BONUS(PTS_BONUS)
  ) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .st(st), .pt(pt),
    .done(done), .pass(pass), .level_bcd(level_bcd), .timer_bcd(timer_bcd),
    .points_bcd(points_bcd), .seg7(seg7)
  );

  scoreboard_controller_gen #(
    .PTS_DIGITS(2), .TIME_SEC(TIME_SEC), .BONUS_SEC(BONUS_SEC), .NUM_LEVELS(NUM_LEVELS),
    .PASS_STEP(PASS_STEP), .PTS_NORMAL(PTS_NORMAL), .PTS_BONUS(PTS_BONUS)
  ) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .st(st), .pt(pt),
    .done(done2), .pass(pass2), .level_bcd(level2), .timer_bcd(timer2),
    .points_bcd(points2), .seg7(seg7_2)
  );

  int checks = 0;
  int errors = 0;

  int m_phase, m_timer, m_level, m_s3, m_s2;
  bit m_done, m_pass, m_st_q, m_pt_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [63:0] to_bcd(input int v, input int n);
    logic [63:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_seg(input int pts, input int n);
    logic [63:0] e;
    e = '0;
    for (int i = n - 1; i >= 0; i--) e = (e << 7) | 64'(seg_of((pts / (10 ** i)) % 10));
    e = (e << 7) | 64'(seg_of(m_timer / 10));
    e = (e << 7) | 64'(seg_of(m_timer % 10));
    e = (e << 7) | 64'(seg_of(m_level));
    return e;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_timer = TIME_SEC; m_level = 1; m_s3 = 0; m_s2 = 0;
    m_done = 1'b0; m_pass = 1'b0; m_st_q = 1'b0; m_pt_q = 1'b0;
  endtask

  task automatic model_update(input bit a_rst, input bit a_tick, input bit a_st, input bit a_pt);
    bit st_e, pt_e;
    int add;
    st_e = a_st && !m_st_q;
    pt_e = a_pt && !m_pt_q;
    if (a_rst) begin
      model_reset();
    end else begin
      m_st_q = a_st;
      m_pt_q = a_pt;
      case (m_phase)
        P_IDLE: if (st_e) m_phase = P_LOAD;
        P_LOAD: begin
          m_s3 = 0; m_s2 = 0; m_level = 1; m_timer = TIME_SEC;
          m_done = 1'b0; m_pass = 1'b0; m_phase = P_PLAY;
        end
        P_PLAY: begin
          if (m_timer == 0) m_phase = P_EVAL;
          if (pt_e) begin
            add = (m_timer <= BONUS_SEC) ? PTS_BONUS : PTS_NORMAL;
            m_s3 = (m_s3 + add > 999) ? 999 : m_s3 + add;
            m_s2 = (m_s2 + add > 99) ? 99 : m_s2 + add;
          end
          if (a_tick && m_timer > 0) m_timer = m_timer - 1;
        end
        P_EVAL: begin
          if (m_s3 >= m_level * PASS_STEP && m_level < NUM_LEVELS) begin
            m_phase = P_NEXT;
          end else begin
            m_done = 1'b1;
            m_pass = (m_s3 >= m_level * PASS_STEP);
            m_phase = P_DONE;
          end
        end
        P_NEXT: begin
          m_level = m_level + 1; m_timer = TIME_SEC; m_phase = P_PLAY;
        end
        default: if (st_e) m_phase = P_LOAD;
      endcase
    end
  endtask

  task automatic compare_all();
    check("done",    64'(done),       64'(m_done));
    check("pass",    64'(pass),       64'(m_pass));
    check("level",   64'(level_bcd),  to_bcd(m_level, 1));
    check("timer",   64'(timer_bcd),  to_bcd(m_timer, 2));
    check("points",  64'(points_bcd), to_bcd(m_s3, 3));
    check("seg7",    64'(seg7),       exp_seg(m_s3, 3));
    check("done2",   64'(done2),      64'(m_done));
    check("pass2",   64'(pass2),      64'(m_pass));
    check("level2",  64'(level2),     to_bcd(m_level, 1));
    check("timer2",  64'(timer2),     to_bcd(m_timer, 2));
    check("points2", 64'(points2),    to_bcd(m_s2, 2));
    check("seg7_2",  64'(seg7_2),     exp_seg(m_s2, 2));
  endtask

  task automatic step(input bit a_rst, input bit a_tick, input bit a_st, input bit a_pt);
    rst = a_rst; tick = a_tick; st = a_st; pt = a_pt;
    @(posedge clk);
    model_update(a_rst, a_tick, a_st, a_pt);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_timer", 64'(timer_bcd), 64'h60);
    check("rst_points", 64'(points_bcd), 64'h000);
    check("rst_done", 64'(done), 64'h0);

    start();
    check("start_timer", 64'(timer_bcd), 64'h60);
    check("start_level", 64'(level_bcd), 64'h1);

    ticks(20);
    pulses(3);
    check("normal_x3", 64'(points_bcd), 64'h006);

    ticks(24);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("tick_pt_timer", 64'(timer_bcd), 64'h15);
    check("tick_pt_points", 64'(points_bcd), 64'h008);
    pulses(1);
    check("bonus_at_15", 64'(points_bcd), 64'h011);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("held_pt", 64'(points_bcd), 64'h014);
    pulses(2);
    check("reach_020", 64'(points_bcd), 64'h020);

    ticks(15);
    idle(3);
    check("next_level", 64'(level_bcd), 64'h2);
    check("next_timer", 64'(timer_bcd), 64'h60);
    check("next_points", 64'(points_bcd), 64'h020);

    ticks(59);
    pulses(6);
    check("pre_expiry", 64'(points_bcd), 64'h038);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);
    check("win_done", 64'(done), 64'h1);
    check("win_pass", 64'(pass), 64'h1);
    check("win_points", 64'(points_bcd), 64'h041);

    start();
    check("restart_points", 64'(points_bcd), 64'h000);
    check("restart_done", 64'(done), 64'h0);
    pulses(9);
    ticks(60);
    idle(2);
    check("fail_done", 64'(done), 64'h1);
    check("fail_pass", 64'(pass), 64'h0);
    check("fail_level", 64'(level_bcd), 64'h1);
    pulses(2);
    check("done_pt_ignored", 64'(points_bcd), 64'h018);

    start();
    pulses(10);
    ticks(60);
    idle(3);
    ticks(27);
    check("mid_timer", 64'(timer_bcd), 64'h33);
    check("mid_level", 64'(level_bcd), 64'h2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_rst_timer", 64'(timer_bcd), 64'h60);
    check("mid_rst_level", 64'(level_bcd), 64'h1);
    pulses(2);
    check("idle_pt_ignored", 64'(points_bcd), 64'h000);

    start();
    pulses(49);
    check("sat_98", 64'(points2), 64'h98);
    pulses(1);
    check("sat_99", 64'(points2), 64'h99);
    pulses(1);
    check("sat_hold", 64'(points2), 64'h99);
    check("wide_102", 64'(points_bcd), 64'h102);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
